// File: rtl/result_frame_decoder.sv
// Result frame decoder: hunts for the 0xAA start byte in a UART byte stream,
// collects the 32-byte miner result frame, checks the repeated sync byte and
// (optionally) the fixed trailer, and publishes the nonce from each good frame.
// Abandoned frames (bad sync, bad trailer, inter-byte timeout) pulse frame_err.

module result_frame_decoder #(
  parameter int TIMEOUT_CYCLES = 30000,
  parameter bit CHECK_TRAILER  = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [31:0]      nonce_out,
  output logic             nonce_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]  SYNC_BYTE = 8'hAA;
  // Trailer b24..b31, LS byte first on the wire.
  localparam logic [63:0] TRAILER   = 64'hdead432987beefaa;
  localparam int          TIMER_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  state_t             state, state_nx;
  logic [4:0]         idx, idx_nx;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic [31:0]        shadow, shadow_nx;
  logic               good_evt;
  logic               err_evt;
  logic [7:0]         trailer_byte;

  // idx 24..31 map onto trailer bytes 0..7 through the low three index bits.
  assign trailer_byte = TRAILER[{idx[2:0], 3'b000} +: 8];

  assign busy = (state == BODY);

  // Next-state and frame checking: decides, per cycle, whether the frame
  // continues, completes (good_evt) or is abandoned (err_evt).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nx  = state;
    idx_nx    = idx;
    timer_nx  = timer;
    shadow_nx = shadow;
    good_evt  = 1'b0;
    err_evt   = 1'b0;

    unique case (state)
      IDLE: begin
        // Only a sync byte opens a frame; everything else is dropped quietly.
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_nx = BODY;
          idx_nx   = 5'd1;
          timer_nx = '0;
        end
      end

      BODY: begin
        if (rx_valid) begin
          // A byte always wins over a coincident timeout cycle.
          timer_nx = '0;
          idx_nx   = idx + 5'd1;

          case (idx)
            5'd1:    shadow_nx[7:0]   = rx_data;
            5'd2:    shadow_nx[15:8]  = rx_data;
            5'd3:    shadow_nx[23:16] = rx_data;
            5'd4:    shadow_nx[31:24] = rx_data;
            default: ;
          endcase

          if (idx == 5'd5 && rx_data != SYNC_BYTE) begin
            err_evt = 1'b1;
          end else if (CHECK_TRAILER && idx >= 5'd24 && rx_data != trailer_byte) begin
            err_evt = 1'b1;
          end else if (idx == 5'd31) begin
            good_evt = 1'b1;
          end

          // The failing byte itself is not reconsidered as a new start byte.
          if (err_evt || good_evt) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end
        end else if (timer == TIMER_LAST) begin
          err_evt  = 1'b1;
          state_nx = IDLE;
          idx_nx   = '0;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
        timer_nx = '0;
      end
    endcase
  end

  // Frame-tracking state: FSM state, byte index, inter-byte timer, shadow nonce.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      timer  <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      timer  <= timer_nx;
      shadow <= shadow_nx;
    end
  end

  // Published outputs: nonce only moves on a good frame; event pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_out   <= '0;
      nonce_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      nonce_valid <= good_evt;
      frame_err   <= err_evt;
      if (good_evt) begin
        nonce_out <= shadow;
      end
    end
  end

  // Frame statistics: saturating counters that hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_count <= '0;
      err_count  <= '0;
    end else begin
      if (good_evt && good_count != '1) begin
        good_count <= good_count + CNT_W'(1);
      end
      if (err_evt && err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_result_frame_decoder.sv
// Directed bench for result_frame_decoder. Two instances share one byte
// stream: u_dut checks the trailer with 16-bit counters, u_dut_nt ignores the
// trailer and has 2-bit counters so saturation is reachable quickly.

module tb_result_frame_decoder;

  localparam int TIMEOUT = 40;
  localparam int GAP     = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [31:0] nonce_out, nonce_out_nt;
  logic        nonce_valid, nonce_valid_nt;
  logic        frame_err, frame_err_nt;
  logic        busy, busy_nt;
  logic [15:0] good_count, err_count;
  logic [1:0]  good_count_nt, err_count_nt;

  int n_checks = 0;
  int n_fail   = 0;
  int nv_cnt;
  int both_cnt;

  result_frame_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CHECK_TRAILER (1'b1),
    .CNT_W         (16)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .nonce_out  (nonce_out),
    .nonce_valid(nonce_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .good_count (good_count),
    .err_count  (err_count)
  );

  result_frame_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CHECK_TRAILER (1'b0),
    .CNT_W         (2)
  ) u_dut_nt (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .nonce_out  (nonce_out_nt),
    .nonce_valid(nonce_valid_nt),
    .frame_err  (frame_err_nt),
    .busy       (busy_nt),
    .good_count (good_count_nt),
    .err_count  (err_count_nt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor for the trailer-checking instance; cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_cnt   <= 0;
    end else if (nonce_valid) begin
      nv_cnt   <= nv_cnt + 1;
    end
  end

  // Flags any cycle where both event pulses are high on either instance.
  always @(posedge clk) begin
    if ((nonce_valid && frame_err) || (nonce_valid_nt && frame_err_nt)) begin
      both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one byte for one cycle; returns at the negedge after it was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends frame bytes 0..last_idx; after byte stall_at the gap is stall_len
  // idle cycles instead of GAP-1. Returns right after the last byte is sampled.
  task automatic send_frame(input logic [31:0] nonce, input logic [7:0] b5,
                            input logic [7:0] b31, input int gap,
                            input int stall_at, input int stall_len, input int last_idx);
    logic [63:0] tr;
    logic [7:0]  b;
    tr = 64'hdead432987beefaa;
    for (int i = 0; i <= last_idx; i++) begin
      if (i == 0)       b = 8'hAA;
      else if (i <= 4)  b = nonce[(i-1)*8 +: 8];
      else if (i == 5)  b = b5;
      else if (i <= 23) b = 8'(i * 7);
      else if (i <= 30) b = tr[(i-24)*8 +: 8];
      else              b = b31;
      send_byte(b);
      if (i != last_idx) begin
        if (i == stall_at) idle(stall_len);
        else               idle(gap - 1);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    both_cnt = 0;
    idle(3);
    check("rst_nonce_out", nonce_out, 0);
    check("rst_nonce_valid", nonce_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_good_count", good_count, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    idle(2);

    // 1: good frame
    send_frame(32'hb2957c02, 8'hAA, 8'hDE, GAP, -1, 0, 31);
    check("t1_nonce_valid", nonce_valid, 1);
    check("t1_nonce_out", nonce_out, 32'hb2957c02);
    check("t1_good_count", good_count, 1);
    check("t1_busy", busy, 0);
    idle(1);
    check("t1_pulse_end", nonce_valid, 0);

    // 2: leading junk then a good frame
    send_byte(8'h00); idle(3);
    send_byte(8'hFF); idle(3);
    send_byte(8'h55);
    check("t2_junk_busy", busy, 0);
    check("t2_junk_no_err", frame_err, 0);
    idle(3);
    send_frame(32'h00000001, 8'hAA, 8'hDE, GAP, -1, 0, 31);
    check("t2_nonce_out", nonce_out, 32'h1);
    check("t2_good_count", good_count, 2);
    check("t2_err_count", err_count, 0);
    idle(3);

    // 3: bad second sync byte, then recovery
    send_frame(32'h44332211, 8'hAB, 8'hDE, GAP, -1, 0, 5);
    check("t3_frame_err", frame_err, 1);
    check("t3_err_count", err_count, 1);
    check("t3_nonce_held", nonce_out, 32'h1);
    check("t3_busy", busy, 0);
    check("t3_nt_err_count", err_count_nt, 1);
    idle(1);
    check("t3_err_pulse_end", frame_err, 0);
    idle(2);
    send_frame(32'h12345678, 8'hAA, 8'hDE, GAP, -1, 0, 31);
    check("t3_recover_nonce", nonce_out, 32'h12345678);
    check("t3_good_count", good_count, 3);
    idle(3);

    // 4: wrong last trailer byte; checked instance rejects, unchecked accepts
    send_frame(32'hcafef00d, 8'hAA, 8'hDF, GAP, -1, 0, 31);
    check("t4_frame_err", frame_err, 1);
    check("t4_no_nonce_valid", nonce_valid, 0);
    check("t4_nonce_held", nonce_out, 32'h12345678);
    check("t4_err_count", err_count, 2);
    check("t4_nt_nonce_valid", nonce_valid_nt, 1);
    check("t4_nt_nonce_out", nonce_out_nt, 32'hcafef00d);
    check("t4_nt_good_sat", good_count_nt, 2'd3);
    idle(3);

    // Back-to-back bytes and back-to-back frames
    send_frame(32'h0badf00d, 8'hAA, 8'hDE, 1, -1, 0, 31);
    check("b2b_first_nonce", nonce_out, 32'h0badf00d);
    send_frame(32'h89abcdef, 8'hAA, 8'hDE, 1, -1, 0, 31);
    check("b2b_second_valid", nonce_valid, 1);
    check("b2b_second_nonce", nonce_out, 32'h89abcdef);
    check("b2b_good_count", good_count, 5);
    idle(3);

    // 5: stall after b10 until timeout
    send_frame(32'h55667788, 8'hAA, 8'hDE, GAP, -1, 0, 10);
    idle(TIMEOUT - 1);
    check("t5_pre_timeout_err", frame_err, 0);
    check("t5_pre_timeout_busy", busy, 1);
    idle(1);
    check("t5_timeout_err", frame_err, 1);
    check("t5_timeout_busy", busy, 0);
    check("t5_err_count", err_count, 3);
    check("t5_nt_err_count", err_count_nt, 2);
    idle(3);
    // Byte arriving on the would-be timeout cycle keeps the frame alive.
    send_frame(32'h0f1e2d3c, 8'hAA, 8'hDE, GAP, 10, TIMEOUT - 1, 31);
    check("t5_byte_wins_valid", nonce_valid, 1);
    check("t5_byte_wins_nonce", nonce_out, 32'h0f1e2d3c);
    check("t5_byte_wins_err", err_count, 3);
    check("t5_good_count", good_count, 6);
    idle(3);

    // 6: reset in the middle of a frame
    send_frame(32'h99999999, 8'hAA, 8'hDE, GAP, -1, 0, 15);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_nonce", nonce_out, 0);
    check("t6_rst_good", good_count, 0);
    send_byte(8'h70); idle(3);
    send_byte(8'h77); idle(3);
    check("t6_leftover_busy", busy, 0);
    send_frame(32'h13579bdf, 8'hAA, 8'hDE, GAP, -1, 0, 31);
    idle(3);
    check("t6_one_pulse", nv_cnt, 1);
    check("t6_nonce_out", nonce_out, 32'h13579bdf);
    check("t6_good_count", good_count, 1);
    check("t6_err_count", err_count, 0);
    check("t6_nt_good_count", good_count_nt, 1);
    check("no_dual_pulse", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
